// File: rtl/typed_stage_pkg.sv
// rtl/typed_stage_pkg.sv - shared types, defaults and width helper for typed_stage_fifo
package typed_stage_pkg;

  typedef logic [7:0] byte_payload_t;

  localparam int DEFAULT_DEPTH = 4;

  // Pointer width never collapses to zero bits, even for tiny depths.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/typed_stage_mem.sv
// rtl/typed_stage_mem.sv - PAYLOAD_T storage array, sync write port, async read port
module typed_stage_mem
  import typed_stage_pkg::*;
#(
  parameter type PAYLOAD_T = byte_payload_t,
  parameter int  DEPTH     = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [clog2_min1(DEPTH)-1:0] waddr,
  input  PAYLOAD_T                     wdata,
  input  logic [clog2_min1(DEPTH)-1:0] raddr,
  output PAYLOAD_T                     rdata
);

  PAYLOAD_T mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/typed_stage_fifo.sv
// rtl/typed_stage_fifo.sv - type-parameterized valid/ready FIFO stage; optional hwm port via TYPED_STAGE_FIFO_HWM_EN
module typed_stage_fifo
  import typed_stage_pkg::*;
#(
  parameter type PAYLOAD_T = byte_payload_t,
  parameter int  DEPTH     = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  PAYLOAD_T               in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output PAYLOAD_T               out_data,
  output logic [$clog2(DEPTH):0] count
`ifdef TYPED_STAGE_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH):0] hwm
`endif
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  PAYLOAD_T      head_data;

  // Handshakes derive from registered count only, so there is no in->out path.
  assign in_ready  = !rst && (count != FULL_COUNT);
  assign out_valid = !rst && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head_data : PAYLOAD_T'(0);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

`ifdef TYPED_STAGE_FIFO_HWM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm <= '0;
    end else if (count_next > hwm) begin
      hwm <= count_next;
    end
  end
`endif

  typed_stage_mem #(
    .PAYLOAD_T (PAYLOAD_T),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

endmodule

// File: tb/tb_typed_stage_fifo.sv
// tb/tb_typed_stage_fifo.sv - queue-model bench for typed_stage_fifo, byte and struct payloads
module tb_typed_stage_fifo;

  typedef struct packed {
    logic [3:0] a;
    logic       b;
  } small_t;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_in_data = 8'h00;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [7:0] a_out_data;
  logic [2:0] a_count;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  small_t     b_in_data = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  small_t     b_out_data;
  logic [2:0] b_count;

`ifdef TYPED_STAGE_FIFO_HWM_EN
  logic [2:0] a_hwm;
  logic [2:0] b_hwm;
`endif

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] aq[$];
  small_t     bq[$];
  int         a_hwm_m = 0;
  int         b_hwm_m = 0;

  always #5 clk = ~clk;

  typed_stage_fifo #(.PAYLOAD_T(logic [7:0]), .DEPTH(DEPTH)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
`ifdef TYPED_STAGE_FIFO_HWM_EN
    ,
    .hwm       (a_hwm)
`endif
  );

  typed_stage_fifo #(.PAYLOAD_T(small_t), .DEPTH(DEPTH)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
`ifdef TYPED_STAGE_FIFO_HWM_EN
    ,
    .hwm       (b_hwm)
`endif
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO contents as queues, updated on each rising edge.
  always @(posedge clk) begin : model
    bit pa_push, pa_pop, pb_push, pb_pop;
    if (rst) begin
      aq.delete();
      bq.delete();
      a_hwm_m = 0;
      b_hwm_m = 0;
    end else begin
      pa_pop  = (aq.size() != 0) && a_out_ready;
      pa_push = a_in_valid && (aq.size() < DEPTH);
      pb_pop  = (bq.size() != 0) && b_out_ready;
      pb_push = b_in_valid && (bq.size() < DEPTH);
      if (pa_pop)  void'(aq.pop_front());
      if (pa_push) aq.push_back(a_in_data);
      if (pb_pop)  void'(bq.pop_front());
      if (pb_push) bq.push_back(b_in_data);
      if (aq.size() > a_hwm_m) a_hwm_m = aq.size();
      if (bq.size() > b_hwm_m) b_hwm_m = bq.size();
    end
  end

  always @(negedge clk) begin : compare
    bit ea_v, eb_v;
    if (chk_en) begin
      ea_v = !rst && (aq.size() != 0);
      eb_v = !rst && (bq.size() != 0);
      cmp("a_count",     32'(a_count),     32'(aq.size()));
      cmp("a_in_ready",  32'(a_in_ready),  32'(!rst && (aq.size() < DEPTH)));
      cmp("a_out_valid", 32'(a_out_valid), 32'(ea_v));
      cmp("a_out_data",  32'(a_out_data),  ea_v ? 32'(aq[0]) : 32'h0);
      cmp("b_count",     32'(b_count),     32'(bq.size()));
      cmp("b_in_ready",  32'(b_in_ready),  32'(!rst && (bq.size() < DEPTH)));
      cmp("b_out_valid", 32'(b_out_valid), 32'(eb_v));
      cmp("b_out_data",  32'(b_out_data),  eb_v ? 32'(bq[0]) : 32'h0);
`ifdef TYPED_STAGE_FIFO_HWM_EN
      cmp("a_hwm", 32'(a_hwm), 32'(a_hwm_m));
      cmp("b_hwm", 32'(b_hwm), 32'(b_hwm_m));
`endif
    end
  end

  initial begin : stim
    logic [7:0] fill_vals [4];
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset for two cycles, then idle.
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    cmp("rst_count",     32'(a_count),     32'd0);
    cmp("rst_out_valid", 32'(a_out_valid), 32'd0);
    cmp("rst_in_ready",  32'(a_in_ready),  32'd1);
    cmp("rst_out_data",  32'(a_out_data),  32'h0);

    // Fill with out_ready low; fifth push must be held off.
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = fill_vals[i];
      tick();
    end
    cmp("fill_count",    32'(a_count),    32'd4);
    cmp("fill_in_ready", 32'(a_in_ready), 32'd0);
`ifdef TYPED_STAGE_FIFO_HWM_EN
    cmp("fill_hwm", 32'(a_hwm), 32'd4);
`endif
    a_in_data = 8'h55;
    tick();
    cmp("hold_count", 32'(a_count), 32'd4);
    a_in_valid = 1'b0;

    // Drain: 0x11..0x44 on consecutive cycles.
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp("drain_valid", 32'(a_out_valid), 32'd1);
      cmp("drain_data",  32'(a_out_data),  32'(fill_vals[i]));
      tick();
    end
    cmp("drain_empty_valid", 32'(a_out_valid), 32'd0);
    cmp("drain_empty_count", 32'(a_count),     32'd0);
    a_out_ready = 1'b0;

    // Steady push/pop at count=2: output is input delayed by two words.
    a_in_valid = 1'b1;
    a_in_data  = 8'h80;
    tick();
    a_in_data  = 8'h81;
    tick();
    a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data = 8'(8'h82 + i);
      cmp("steady_count", 32'(a_count),    32'd2);
      cmp("steady_data",  32'(a_out_data), 32'(8'h80 + i));
      tick();
    end
    a_in_valid = 1'b0;
    tick();
    tick();
    cmp("steady_drained", 32'(a_count), 32'd0);
    a_out_ready = 1'b0;

    // Full with pop and in_valid: in_ready rises only the cycle after.
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = 8'(8'hA0 + i);
      tick();
    end
    a_in_data   = 8'hA4;
    a_out_ready = 1'b1;
    #1;
    cmp("full_pop_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    cmp("after_pop_in_ready", 32'(a_in_ready), 32'd1);
    cmp("after_pop_count",    32'(a_count),    32'd3);
    a_out_ready = 1'b0;
    tick();
    cmp("refill_count", 32'(a_count), 32'd4);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp("refill_data", 32'(a_out_data), 32'(8'hA1 + i));
      tick();
    end
    a_out_ready = 1'b0;

    // Struct payload: reset with three entries buffered.
    b_in_valid = 1'b1;
    b_in_data  = '{a: 4'h1, b: 1'b1};
    tick();
    b_in_data  = '{a: 4'h2, b: 1'b0};
    tick();
    b_in_data  = '{a: 4'h3, b: 1'b1};
    tick();
    b_in_valid = 1'b0;
    cmp("b_pre_rst_count", 32'(b_count),    32'd3);
    cmp("b_pre_rst_head",  32'(b_out_data), 32'h03);
`ifdef TYPED_STAGE_FIFO_HWM_EN
    cmp("b_pre_rst_hwm", 32'(b_hwm), 32'd3);
`endif
    rst         = 1'b1;
    b_out_ready = 1'b1;
    #1;
    cmp("b_rst_in_ready",  32'(b_in_ready),  32'd0);
    cmp("b_rst_out_valid", 32'(b_out_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    cmp("b_post_rst_count", 32'(b_count),     32'd0);
    cmp("b_post_rst_valid", 32'(b_out_valid), 32'd0);
`ifdef TYPED_STAGE_FIFO_HWM_EN
    cmp("b_post_rst_hwm", 32'(b_hwm), 32'd0);
`endif
    b_in_valid = 1'b1;
    b_in_data  = '{a: 4'h5, b: 1'b0};
    tick();
    b_in_valid = 1'b0;
    cmp("b_new_valid", 32'(b_out_valid), 32'd1);
    cmp("b_new_data",  32'(b_out_data),  32'h0A);
    tick();
    cmp("b_final_valid", 32'(b_out_valid), 32'd0);
    b_out_ready = 1'b0;
    tick();
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
